window_gen: RTL and testbench
=============================

// Module: window_gen
// PURPOSE
//  Turns a raster pixel stream (one 10-bit value/beat) into 3x3 windows (9 x 10 bit = 90 bit), stride 1, same padding.
//  Sits directly upstream of the 1x1/3x3 mask stage and drives its 90-bit data bus.
//  Packing: slot k = o_data[10k+9:10k]. Slot 0 = centre pixel (the only slot kept in 1x1 mode); slots 1..8 = NW,N,NE,W,E,SW,S,SE.
// PARAMETERS
//  DATA_W  10  pixel width; fixed by the 90-bit bus, other values unsupported.
//  IMG_W   16  image width in pixels, >=2; also the depth of each line buffer.
//  IMG_H   16  image height in rows, >=2.
// PORTS
//  i_clk        in   1   clock; single clock domain.
//  i_rst_n      in   1   asynchronous active-low reset.
//  i_start      in   1   frame start pulse; honoured only in IDLE.
//  i_in_valid   in   1   upstream pixel valid.
//  o_in_ready   out  1   pixel accepted when i_in_valid & o_in_ready.
//  i_data       in   10  pixel, raster order, row 0 first.
//  o_out_valid  out  1   window valid.
//  i_out_ready  in   1   downstream ready; window consumed when o_out_valid & i_out_ready.
//  o_data       out  90  3x3 window, packed as above.
//  o_last       out  1   qualifies the final window of the frame (centre IMG_H-1, IMG_W-1).
//  o_busy       out  1   high from i_start acceptance until the last window is consumed.
// BEHAVIOUR
//  Reset (async): state IDLE; o_in_ready, o_out_valid, o_last, o_busy = 0; o_data = 0; all counters 0. Line-buffer RAM is not reset; border masking hides stale contents.
//  FSM: IDLE -i_start-> FILL -(IMG_W+1 pixels accepted)-> RUN -(IMG_W*IMG_H pixels accepted)-> FLUSH -(last window consumed)-> IDLE.
//  FILL: accepts pixels, emits no windows. o_in_ready = 1.
//  RUN: each accepted pixel emits exactly one window. The output register loads on the cycle after acceptance.
//  Latency: the window centred at (0,0) becomes valid 1 cycle after the (IMG_W+2)-th pixel is accepted.
//  FLUSH: o_in_ready = 0. A zero column is fed internally to emit the remaining IMG_W+1 windows, one per consumed beat.
//  Backpressure: o_in_ready = (state==FILL) | (state==RUN & (!o_out_valid | i_out_ready)).
//  o_out_valid/o_data/o_last hold stable while o_out_valid & !i_out_ready (no drop, no duplicate).
//  Datapath: two IMG_W-deep line buffers and a 3x3 shift register of columns {lb1 out, lb0 out, new pixel}.
//  Centre row/col counters (wrap col at IMG_W-1, row at IMG_H-1) zero every slot whose neighbour lies outside the image (row -1/IMG_H, col -1/IMG_W).
//  Windows are emitted in raster order of centre, exactly IMG_W*IMG_H per frame.
//  i_start outside IDLE: ignored. Input beats when o_in_ready=0: ignored, not stored.
//  Reset mid-frame: frame is abandoned, block returns to IDLE; the next frame needs a new i_start.
// CONFIGURATION
//  WINDOW_GEN_REPLICATE_PAD_EN defined: out-of-image slots take the nearest in-image pixel (edge replication) instead of 0.
//  Not defined: zero padding as above. Handshake, latency and window count are identical in both builds.
// STRUCTURE
//  Package win_pkg: DATA_W=10, WIN_SLOTS=9, WIN_W=90, slot index localparams (SLOT_C=0, SLOT_NW=1 .. SLOT_SE=8), FSM state encoding.
//  Sub-module line_buf (IMG_W x DATA_W delay line with shift-enable), instantiated twice. Counters, FSM and padding mux stay in window_gen.
// TESTING (IMG_W=4, IMG_H=4, pixel(r,c)=4r+c+1, zero padding unless stated)
//  Stream 16 pixels, i_out_ready=1 -> first o_out_valid 1 cycle after 6th accept; window(0,0) slots C..SE = 1,0,0,0,0,2,0,5,6.
//  Same stream -> window(1,1) = 6,1,2,3,5,7,9,10,11; 16 windows total; o_last only on window(3,3) = 16,11,12,0,15,0,0,0,0.
//  Hold i_out_ready=0 for 5 cycles mid-RUN -> o_in_ready=0, o_data frozen; resume -> no loss or duplication, sequence matches golden model.
//  After 16th accept -> o_in_ready=0, exactly 5 flush windows, o_busy falls after o_last is consumed; i_start during flush is ignored.
//  Assert i_rst_n low after 9 pixels -> all outputs 0 immediately; new i_start + full frame -> correct 16 windows.
//  With WINDOW_GEN_REPLICATE_PAD_EN -> window(0,0) = 1,1,1,2,1,2,5,5,6.

Source files
------------

// File: rtl/win_pkg.sv
// Shared constants, slot map and FSM encoding for the 3x3 window generator.
// Slot k of the window bus occupies bits [DATA_W*k +: DATA_W].
package win_pkg;

  localparam int DATA_W    = 10;
  localparam int WIN_SLOTS = 9;
  localparam int WIN_W     = WIN_SLOTS * DATA_W;

  localparam int SLOT_C  = 0;
  localparam int SLOT_NW = 1;
  localparam int SLOT_N  = 2;
  localparam int SLOT_NE = 3;
  localparam int SLOT_W  = 4;
  localparam int SLOT_E  = 5;
  localparam int SLOT_SW = 6;
  localparam int SLOT_S  = 7;
  localparam int SLOT_SE = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Grid position (row 0 = north, col 0 = west) to bus slot.
  function automatic int slot_of(input int rr, input int cc);
    int s;
    case (rr * 3 + cc)
      0:       s = SLOT_NW;
      1:       s = SLOT_N;
      2:       s = SLOT_NE;
      3:       s = SLOT_W;
      4:       s = SLOT_C;
      5:       s = SLOT_E;
      6:       s = SLOT_SW;
      7:       s = SLOT_S;
      default: s = SLOT_SE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/window_gen_line_buf.sv
// Fixed-length delay line: o_q is the sample pushed DEPTH enables ago.
// Storage is deliberately unreset; consumers mask stale contents.
module line_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 10
) (
  input  logic         i_clk,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      mem_q[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign o_q = mem_q[DEPTH-1];

endmodule

// File: rtl/window_gen.sv
// Raster stream to 3x3 window generator, stride 1, same padding.
// WINDOW_GEN_REPLICATE_PAD_EN selects edge replication instead of zeros.
module window_gen
  import win_pkg::*;
#(
  parameter int DATA_W = win_pkg::DATA_W,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [DATA_W-1:0]           i_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [WIN_SLOTS*DATA_W-1:0] o_data,
  output logic                        o_last,
  output logic                        o_busy
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int RW   = $clog2(IMG_H);
  localparam int CLW  = $clog2(IMG_W);
  localparam int FW   = $clog2(IMG_W + 2);
  localparam int OW   = WIN_SLOTS * DATA_W;

  localparam logic [CW-1:0]  FILL_END = CW'(IMG_W);
  localparam logic [CW-1:0]  LAST_PIX = CW'(NPIX - 1);
  localparam logic [RW-1:0]  ROW_MAX  = RW'(IMG_H - 1);
  localparam logic [CLW-1:0] COL_MAX  = CLW'(IMG_W - 1);
  localparam logic [FW-1:0]  FLUSH_N  = FW'(IMG_W + 1);

  state_e state_q, state_d;

  logic [CW-1:0]  in_cnt_q, in_cnt_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CLW-1:0] col_q, col_d;
  logic [FW-1:0]  flush_q, flush_d;

  logic              vld_q, vld_d;
  logic [OW-1:0]     dat_q, dat_d;
  logic              last_q, last_d;

  logic [DATA_W-1:0] c0_q [3];
  logic [DATA_W-1:0] c1_q [3];
  logic [DATA_W-1:0] ncol [3];
  logic [DATA_W-1:0] grid [3][3];

  logic [DATA_W-1:0] lb0_q, lb1_q, px;
  logic              out_free, in_rdy, acc;
  logic              flush_step, shift, emit, at_end;
  logic [2:0]        row_ok, col_ok;
  logic [OW-1:0]     win_flat;

  assign out_free   = !vld_q | i_out_ready;
  assign in_rdy     = (state_q == ST_FILL)
                    | ((state_q == ST_RUN) & out_free);
  assign acc        = in_rdy & i_in_valid;
  assign flush_step = (state_q == ST_FLUSH)
                    & (flush_q != '0) & out_free;
  assign shift      = acc | flush_step;
  assign emit       = shift & (state_q != ST_FILL);
  assign px         = flush_step ? '0 : i_data;
  assign at_end     = (row_q == ROW_MAX) & (col_q == COL_MAX);

  line_buf #(
    .DEPTH(IMG_W),
    .W    (DATA_W)
  ) u_lb0 (
    .i_clk(i_clk),
    .i_en (shift),
    .i_d  (px),
    .o_q  (lb0_q)
  );

  line_buf #(
    .DEPTH(IMG_W),
    .W    (DATA_W)
  ) u_lb1 (
    .i_clk(i_clk),
    .i_en (shift),
    .i_d  (lb0_q),
    .o_q  (lb1_q)
  );

  // Incoming column: row above centre, centre row, row below.
  assign ncol[0] = lb1_q;
  assign ncol[1] = lb0_q;
  assign ncol[2] = px;

  assign row_ok = {row_q != ROW_MAX, 1'b1, row_q != '0};
  assign col_ok = {col_q != COL_MAX, 1'b1, col_q != '0};

  always_comb begin
    for (int rr = 0; rr < 3; rr++) begin
      grid[rr][0] = c0_q[rr];
      grid[rr][1] = c1_q[rr];
      grid[rr][2] = ncol[rr];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int rr = 0; rr < 3; rr++) begin
      for (int cc = 0; cc < 3; cc++) begin
`ifdef WINDOW_GEN_REPLICATE_PAD_EN
        // Out-of-image neighbours fold onto the centre row/column.
        win_flat[slot_of(rr, cc)*DATA_W +: DATA_W] =
          grid[row_ok[rr] ? rr : 1][col_ok[cc] ? cc : 1];
`else
        if (row_ok[rr] && col_ok[cc]) begin
          win_flat[slot_of(rr, cc)*DATA_W +: DATA_W] = grid[rr][cc];
        end
`endif
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    flush_d  = flush_q;
    vld_d    = vld_q;
    dat_d    = dat_q;
    last_d   = last_q;

    if (vld_q && i_out_ready) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end

    if (emit) begin
      vld_d  = 1'b1;
      dat_d  = win_flat;
      last_d = at_end;
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d  = ST_FILL;
          in_cnt_d = '0;
          row_d    = '0;
          col_d    = '0;
        end
      end
      ST_FILL: begin
        if (acc) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == FILL_END) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (acc) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == LAST_PIX) begin
            state_d = ST_FLUSH;
            flush_d = FLUSH_N;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_step) flush_d = flush_q - 1'b1;
        if (vld_q && i_out_ready && last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      in_cnt_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      flush_q  <= '0;
      vld_q    <= 1'b0;
      dat_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      flush_q  <= flush_d;
      vld_q    <= vld_d;
      dat_q    <= dat_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int rr = 0; rr < 3; rr++) begin
        c0_q[rr] <= '0;
        c1_q[rr] <= '0;
      end
    end else if (shift) begin
      for (int rr = 0; rr < 3; rr++) begin
        c0_q[rr] <= c1_q[rr];
        c1_q[rr] <= ncol[rr];
      end
    end
  end

  assign o_in_ready  = in_rdy;
  assign o_out_valid = vld_q;
  assign o_data      = dat_q;
  assign o_last      = last_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen at IMG_W=IMG_H=4: vector table, corner sequences,
// and random frames checked against a coordinate-level window model.
module tb_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int DW = 10;
  localparam int WW = 9 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] din = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WW-1:0] dout;
  logic          last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  int pix [N];
  int DR [9] = '{0, -1, -1, -1, 0, 0, 1, 1, 1};
  int DC [9] = '{0, -1, 0, 1, -1, 1, -1, 0, 1};

  logic [WW-1:0] got_d [$];
  bit            got_l [$];
  int flush_wins, first_v, acc6, acc16;

  typedef struct {
    int            r;
    int            c;
    logic [WW-1:0] w;
    bit            l;
  } vec_t;
  vec_t vec [6];

  always #5 clk = ~clk;

  window_gen #(
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_data     (din),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_data     (dout),
    .o_last     (last),
    .o_busy     (busy)
  );

  task automatic chk(input string nm, input logic [WW-1:0] act,
                     input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] pk(input int a0, input int a1,
    input int a2, input int a3, input int a4, input int a5,
    input int a6, input int a7, input int a8);
    return {10'(a8), 10'(a7), 10'(a6), 10'(a5), 10'(a4),
            10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  // Window centred on raster index idx, from image coordinates.
  function automatic logic [WW-1:0] model(input int idx);
    logic [WW-1:0] w;
    int r, c, rr, cc;
    w = '0;
    r = idx / W;
    c = idx % W;
    for (int k = 0; k < 9; k++) begin
      rr = r + DR[k];
      cc = c + DC[k];
`ifdef WINDOW_GEN_REPLICATE_PAD_EN
      rr = (rr < 0) ? 0 : ((rr >= H) ? H - 1 : rr);
      cc = (cc < 0) ? 0 : ((cc >= W) ? W - 1 : cc);
      w[k*DW +: DW] = 10'(pix[rr*W + cc]);
`else
      if (rr >= 0 && rr < H && cc >= 0 && cc < W)
        w[k*DW +: DW] = 10'(pix[rr*W + cc]);
`endif
    end
    return w;
  endfunction

  task automatic run_frame(input int vpct, input int rpct,
                           input int stall_at, input bit sif,
                           input int abort_after);
    int acc_n, cyc, stall_left;
    bit stalled, hold, lastc, done, acc, cons;
    logic [WW-1:0] held;
    acc_n = 0; cyc = 0; stall_left = 0;
    stalled = 0; hold = 0; lastc = 0; done = 0;
    held = '0;
    got_d.delete();
    got_l.delete();
    flush_wins = 0; first_v = -1; acc6 = -1; acc16 = -1;
    @(posedge clk); #1;
    start = 1; in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    chki("busy_on_start", int'(busy), 1);
    while (!done && cyc < 3000) begin
      if (acc_n < N) begin
        in_valid = $urandom_range(99) < vpct;
        din = 10'(pix[acc_n]);
      end else begin
        in_valid = 1'($urandom_range(1));
        din = 10'($urandom);
      end
      if (stall_at > 0 && acc_n >= stall_at && !stalled) begin
        stalled = 1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        out_ready = 0;
        stall_left--;
      end else begin
        out_ready = $urandom_range(99) < rpct;
      end
      start = sif && acc_n >= N && !lastc;
      @(negedge clk);
      acc = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (lastc) begin
        chki("busy_fall", int'(busy), 0);
        done = 1;
      end else begin
        if (hold) begin
          chki("hold_valid", int'(out_valid), 1);
          chk("hold_data", dout, held);
        end
        if (out_valid && !out_ready)
          chki("bp_in_ready", int'(in_ready), 0);
        if (acc16 >= 0)
          chki("flush_in_ready", int'(in_ready), 0);
        if (out_valid && first_v < 0) first_v = cyc;
        if (out_valid && !hold && acc16 >= 0 && cyc > acc16 + 1)
          flush_wins++;
        if (cons) begin
          got_d.push_back(dout);
          got_l.push_back(last);
          if (last) lastc = 1;
        end
        if (acc && acc_n < N) begin
          acc_n++;
          if (acc_n == 6) acc6 = cyc;
          if (acc_n == N) acc16 = cyc;
        end
        hold = out_valid && !out_ready;
        held = dout;
      end
      if (abort_after > 0 && acc_n == abort_after) break;
      @(posedge clk); #1;
      cyc++;
    end
    if (abort_after == 0) begin
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout: got %0d windows expected %0d",
                 got_d.size(), N);
      end
      chki("win_count", got_d.size(), N);
      for (int i = 0; i < got_d.size() && i < N; i++) begin
        chk($sformatf("win%0d_data", i), got_d[i], model(i));
        chki($sformatf("win%0d_last", i), int'(got_l[i]),
             (i == N - 1) ? 1 : 0);
      end
      chki("flush_wins", flush_wins, W + 1);
      chki("latency", first_v, acc6 + 1);
    end
    in_valid = 0;
    start = 0;
    out_ready = 0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chki({tag, "_in_ready"}, int'(in_ready), 0);
    chki({tag, "_out_valid"}, int'(out_valid), 0);
    chki({tag, "_last"}, int'(last), 0);
    chki({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_data"}, dout, '0);
  endtask

  task automatic rand_pix();
    for (int i = 0; i < N; i++) pix[i] = int'($urandom_range(1023));
  endtask

  initial begin
`ifdef WINDOW_GEN_REPLICATE_PAD_EN
    vec[0] = '{r:0, c:0, w:pk(1, 1, 1, 2, 1, 2, 5, 5, 6), l:0};
    vec[1] = '{r:1, c:1, w:pk(6, 1, 2, 3, 5, 7, 9, 10, 11), l:0};
    vec[2] = '{r:3, c:3, w:pk(16, 11, 12, 12, 15, 16, 15, 16, 16), l:1};
    vec[3] = '{r:0, c:3, w:pk(4, 3, 4, 4, 3, 4, 7, 8, 8), l:0};
    vec[4] = '{r:2, c:0, w:pk(9, 5, 5, 6, 9, 10, 13, 13, 14), l:0};
    vec[5] = '{r:3, c:0, w:pk(13, 9, 9, 10, 13, 14, 13, 13, 14), l:0};
`else
    vec[0] = '{r:0, c:0, w:pk(1, 0, 0, 0, 0, 2, 0, 5, 6), l:0};
    vec[1] = '{r:1, c:1, w:pk(6, 1, 2, 3, 5, 7, 9, 10, 11), l:0};
    vec[2] = '{r:3, c:3, w:pk(16, 11, 12, 0, 15, 0, 0, 0, 0), l:1};
    vec[3] = '{r:0, c:3, w:pk(4, 0, 0, 0, 3, 0, 7, 8, 0), l:0};
    vec[4] = '{r:2, c:0, w:pk(9, 0, 5, 6, 0, 10, 0, 13, 14), l:0};
    vec[5] = '{r:3, c:0, w:pk(13, 0, 9, 10, 0, 14, 0, 0, 0), l:0};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1;

    for (int i = 0; i < N; i++) pix[i] = i + 1;
    run_frame(100, 100, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      int idx;
      idx = vec[i].r * W + vec[i].c;
      if (idx < got_d.size()) begin
        chk($sformatf("vec%0d_data", i), got_d[idx], vec[i].w);
        chki($sformatf("vec%0d_last", i), int'(got_l[idx]), int'(vec[i].l));
      end else begin
        chki($sformatf("vec%0d_present", i), got_d.size(), idx + 1);
      end
    end

    run_frame(100, 100, 8, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chki("start_in_flush_ignored", int'(busy), 0);

    for (int f = 0; f < 3; f++) begin
      rand_pix();
      run_frame(70, 60, 5 + f, f == 1, 0);
    end

    rand_pix();
    run_frame(100, 80, 0, 0, 9);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk_zero_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    rand_pix();
    run_frame(80, 80, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
